// File: rtl/game_frame_sequencer.sv
// game_frame_sequencer: per-frame controller for the Snoopy game datapath.
// Owns the game state (BEGIN/PLAY/LOST/WON) and steps every played frame
// through erase -> position update -> collision/end check -> draw, using
// req/done handshakes with the shared VGA pixel-writer.
// Optional build macro: GAME_FRAME_SEQUENCER_LIVES_EN adds a lives counter
// and the lives output port; without it the first collision ends the round.
module game_frame_sequencer #(
    parameter int SCORE_W         = 8,
    parameter int END_HOLD_FRAMES = 120,
    parameter int HOLD_W          = 7
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
    ,
    parameter int LIVES_INIT      = 3,
    parameter int LIVES_W         = 2
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               user_input,
    input  logic               collided,
    input  logic               reached_screen_end,
    input  logic               op_done,
    output logic               erase_req,
    output logic               draw_req,
    output logic               pos_update,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic               frame_overrun
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
    ,
    output logic [LIVES_W-1:0] lives
`endif
);

    typedef enum logic [1:0] {
        GAME_BEGIN = 2'b00,
        GAME_PLAY  = 2'b01,
        GAME_LOST  = 2'b10,
        GAME_WON   = 2'b11
    } game_state_t;

    typedef enum logic [2:0] {
        SEQ_WAIT   = 3'd0,
        SEQ_ERASE  = 3'd1,
        SEQ_UPDATE = 3'd2,
        SEQ_CHECK  = 3'd3,
        SEQ_DRAW   = 3'd4
    } seq_state_t;

    game_state_t        game_q;
    seq_state_t         seq_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [SCORE_W-1:0] score_inc;
    logic               hold_last;

    assign game_state = game_q;

    // Saturating score increment and end-of-hold detection used by the FSM.
    always_comb begin
        score_inc = score;
        if (score != '1) begin
            score_inc = score + 1'b1;
        end
        hold_last = (hold_q == HOLD_W'(END_HOLD_FRAMES - 1));
    end

    // Game FSM and frame sequencer; every output is registered here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            game_q        <= GAME_BEGIN;
            seq_q         <= SEQ_WAIT;
            hold_q        <= '0;
            erase_req     <= 1'b0;
            draw_req      <= 1'b0;
            pos_update    <= 1'b0;
            score         <= '0;
            frame_overrun <= 1'b0;
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
            lives         <= LIVES_W'(LIVES_INIT);
`endif
        end else begin
            pos_update <= 1'b0;
            case (game_q)
                GAME_BEGIN: begin
                    if (user_input) begin
                        game_q        <= GAME_PLAY;
                        seq_q         <= SEQ_WAIT;
                        hold_q        <= '0;
                        score         <= '0;
                        frame_overrun <= 1'b0;
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
                        lives         <= LIVES_W'(LIVES_INIT);
`endif
                    end
                end
                default: begin
                    // The sequencer keeps running in LOST/WON so the final
                    // frame's DRAW completes; only PLAY starts new sequences.
                    case (seq_q)
                        SEQ_WAIT: begin
                            if (frame_tick) begin
                                if (game_q == GAME_PLAY) begin
                                    seq_q     <= SEQ_ERASE;
                                    erase_req <= 1'b1;
                                end else if (hold_last) begin
                                    game_q <= GAME_BEGIN;
                                    hold_q <= '0;
                                end else begin
                                    hold_q <= hold_q + 1'b1;
                                end
                            end
                        end
                        SEQ_ERASE: begin
                            if (op_done) begin
                                erase_req  <= 1'b0;
                                pos_update <= 1'b1;
                                seq_q      <= SEQ_UPDATE;
                            end
                        end
                        SEQ_UPDATE: begin
                            seq_q <= SEQ_CHECK;
                        end
                        SEQ_CHECK: begin
                            seq_q    <= SEQ_DRAW;
                            draw_req <= 1'b1;
                            if (collided) begin
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
                                if (lives > LIVES_W'(1)) begin
                                    lives <= lives - 1'b1;
                                end else begin
                                    lives  <= '0;
                                    game_q <= GAME_LOST;
                                end
`else
                                game_q <= GAME_LOST;
`endif
                            end else if (reached_screen_end) begin
                                game_q <= GAME_WON;
                                score  <= score_inc;
                            end else begin
                                score <= score_inc;
                            end
                        end
                        SEQ_DRAW: begin
                            if (op_done) begin
                                draw_req <= 1'b0;
                                seq_q    <= SEQ_WAIT;
                            end
                        end
                        default: begin
                            seq_q <= SEQ_WAIT;
                        end
                    endcase
                    if ((game_q == GAME_PLAY) && (seq_q != SEQ_WAIT) && frame_tick) begin
                        frame_overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_frame_sequencer.sv
// tb_game_frame_sequencer: directed, table-driven bench for game_frame_sequencer.
// Built with a short end hold (4 frames); also valid with
// GAME_FRAME_SEQUENCER_LIVES_EN defined, in which case the lives path is checked.
module tb_game_frame_sequencer;

    localparam int SCORE_W = 8;

    logic               clock;
    logic               reset;
    logic               frame_tick;
    logic               user_input;
    logic               collided;
    logic               reached_screen_end;
    logic               op_done;
    logic               erase_req;
    logic               draw_req;
    logic               pos_update;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic               frame_overrun;
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
    logic [1:0]         lives;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       col;
        logic       rend;
        int         op_delay;
        logic [1:0] exp_state;
        int         exp_score;
        int         exp_lives;
    } frame_vec_t;

    frame_vec_t vecs[$];

    game_frame_sequencer #(
        .SCORE_W(SCORE_W),
        .END_HOLD_FRAMES(4),
        .HOLD_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .frame_tick(frame_tick),
        .user_input(user_input),
        .collided(collided),
        .reached_screen_end(reached_screen_end),
        .op_done(op_done),
        .erase_req(erase_req),
        .draw_req(draw_req),
        .pos_update(pos_update),
        .game_state(game_state),
        .score(score),
        .frame_overrun(frame_overrun)
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
        ,
        .lives(lives)
`endif
    );

    // Free-running 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic tick, input logic user, input logic col,
                                 input logic rend, input logic done);
        frame_tick         = tick;
        user_input         = user;
        collided           = col;
        reached_screen_end = rend;
        op_done            = done;
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    // One full frame: tick, erase held for op_delay cycles, update, check, draw.
    task automatic run_frame(input string name, input logic col, input logic rend, input int op_delay,
                             input logic [1:0] exp_state, input int exp_score, input int exp_lives,
                             input logic tick_at_done);
        int erase_cycles = 0;
        applyStimulus(1'b1, 1'b0, col, rend, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, col, rend, 1'b0);
        checkOutput({name, "_erase_latency"}, erase_req, 1);
        for (int k = 0; k < op_delay; k++) begin
            if (erase_req) erase_cycles++;
            if (k == op_delay - 1) op_done = 1'b1;
            next_cycle();
        end
        op_done = 1'b0;
        checkOutput({name, "_erase_cycles"}, erase_cycles, op_delay);
        checkOutput({name, "_erase_drop"}, erase_req, 0);
        checkOutput({name, "_pos_pulse"}, pos_update, 1);
        next_cycle();
        checkOutput({name, "_pos_single"}, pos_update, 0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_draw_req"}, draw_req, 1);
        checkOutput({name, "_state"}, game_state, exp_state);
        checkOutput({name, "_score"}, score, exp_score);
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
        checkOutput({name, "_lives"}, lives, exp_lives);
`else
        if (exp_lives < 0) $display("[TB] note: negative lives value in vector %s", name);
`endif
        next_cycle();
        checkOutput({name, "_draw_hold"}, draw_req, 1);
        applyStimulus(tick_at_done, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_draw_drop"}, draw_req, 0);
        if (tick_at_done) begin
            checkOutput({name, "_overrun_at_done"}, frame_overrun, 1);
            next_cycle();
            checkOutput({name, "_tick_dropped"}, erase_req, 0);
        end
    endtask

    // Four hold ticks with user_input pressed; only the fourth returns to BEGIN.
    task automatic hold_phase(input string name, input logic [1:0] hold_state);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            next_cycle();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("%s_hold%0d", name, i), game_state, (i < 4) ? hold_state : 2'b00);
            next_cycle();
        end
    endtask

    task automatic start_round(input string name);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({name, "_state"}, game_state, 2'b01);
        checkOutput({name, "_score_clear"}, score, 0);
        checkOutput({name, "_overrun_clear"}, frame_overrun, 0);
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
        checkOutput({name, "_lives_init"}, lives, 3);
`endif
        next_cycle();
    endtask

    // Main directed sequence.
    initial begin
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
        vecs.push_back('{1'b0, 1'b0, 5, 2'b01, 1, 3});
        vecs.push_back('{1'b0, 1'b0, 2, 2'b01, 2, 3});
        vecs.push_back('{1'b0, 1'b0, 1, 2'b01, 3, 3});
        vecs.push_back('{1'b1, 1'b1, 3, 2'b01, 3, 2});
        vecs.push_back('{1'b1, 1'b0, 2, 2'b01, 3, 1});
        vecs.push_back('{1'b1, 1'b0, 2, 2'b10, 3, 0});
`else
        vecs.push_back('{1'b0, 1'b0, 5, 2'b01, 1, 0});
        vecs.push_back('{1'b0, 1'b0, 2, 2'b01, 2, 0});
        vecs.push_back('{1'b0, 1'b0, 1, 2'b01, 3, 0});
        vecs.push_back('{1'b1, 1'b1, 3, 2'b10, 3, 0});
`endif

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        checkOutput("reset_state", game_state, 2'b00);
        checkOutput("reset_score", score, 0);
        checkOutput("reset_overrun", frame_overrun, 0);
        checkOutput("reset_erase", erase_req, 0);
        checkOutput("reset_draw", draw_req, 0);
        checkOutput("reset_pos", pos_update, 0);
`ifdef GAME_FRAME_SEQUENCER_LIVES_EN
        checkOutput("reset_lives", lives, 3);
`endif
        reset = 1'b1;
        next_cycle();

        // Ticks in BEGIN do not sequence frames.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("begin_no_erase", erase_req, 0);
        checkOutput("begin_stays", game_state, 2'b00);
        next_cycle();

        // Round 1: clean frames, then collision ends the round.
        start_round("round1");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stray_done_erase", erase_req, 0);
        checkOutput("stray_done_pos", pos_update, 0);
        checkOutput("stray_done_draw", draw_req, 0);
        next_cycle();
        for (int v = 0; v < vecs.size(); v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].col, vecs[v].rend, vecs[v].op_delay,
                      vecs[v].exp_state, vecs[v].exp_score, vecs[v].exp_lives, 1'b0);
            next_cycle();
        end
        hold_phase("lost", 2'b10);

        // Round 2: overrun during ERASE, then win.
        start_round("round2");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        checkOutput("ovr_erase_on", erase_req, 1);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovr_flag", frame_overrun, 1);
        checkOutput("ovr_erase_still", erase_req, 1);
        checkOutput("ovr_no_pos", pos_update, 0);
        next_cycle();
        checkOutput("ovr_erase_wait", erase_req, 1);
        op_done = 1'b1;
        next_cycle();
        op_done = 1'b0;
        checkOutput("ovr_erase_drop", erase_req, 0);
        checkOutput("ovr_pos", pos_update, 1);
        next_cycle();
        next_cycle();
        checkOutput("ovr_draw", draw_req, 1);
        checkOutput("ovr_score", score, 1);
        op_done = 1'b1;
        next_cycle();
        op_done = 1'b0;
        checkOutput("ovr_draw_drop", draw_req, 0);
        checkOutput("ovr_sticky", frame_overrun, 1);
        next_cycle();
        run_frame("won", 1'b0, 1'b1, 2, 2'b11, 2, 3, 1'b0);
        checkOutput("won_overrun_sticky", frame_overrun, 1);
        next_cycle();
        hold_phase("won", 2'b11);
        checkOutput("begin_overrun_kept", frame_overrun, 1);

        // Round 3: tick coincident with the DRAW op_done, then reset mid-DRAW.
        start_round("round3");
        run_frame("coinc", 1'b0, 1'b0, 1, 2'b01, 1, 3, 1'b1);
        next_cycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        op_done = 1'b0;
        next_cycle();
        next_cycle();
        checkOutput("middraw_req", draw_req, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_draw_drop", draw_req, 0);
        checkOutput("async_state", game_state, 2'b00);
        checkOutput("async_score", score, 0);
        checkOutput("async_overrun", frame_overrun, 0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
